// File: rtl/vga_pkg.sv
// Shared constants and types for the VGA line prefetch path.
// Framebuffer geometry, pixel width, active area, fetch FSM states.
package vga_pkg;

    localparam int FB_W  = 320;
    localparam int FB_H  = 240;
    localparam int PIX_W = 12;
    localparam int ACT_W = 640;
    localparam int ACT_H = 480;
    localparam int AW    = 17;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FETCH = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/line_buffer_2bank.sv
// Two-bank line buffer: one synchronous write port, one async read port.
// The fetch engine fills one bank while the display reads the other.
module line_buffer_2bank #(
    parameter int DEPTH = 320,
    parameter int W     = 12,
    parameter int IW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic          wbank,
    input  logic [IW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic          rbank,
    input  logic [IW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] bank0 [DEPTH];
    logic [W-1:0] bank1 [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            if (wbank)
                bank1[waddr] <= wdata;
            else
                bank0[waddr] <= wdata;
        end
    end

    assign rdata = rbank ? bank1[raddr] : bank0[raddr];

endmodule

// File: rtl/vga_line_prefetch.sv
// Line prefetcher feeding the VGA timing stage from a double-banked
// line buffer; fetches the next framebuffer line over a req/ack port.
module vga_line_prefetch #(
    parameter int FB_W = vga_pkg::FB_W,
    parameter int FB_H = vga_pkg::FB_H,
    parameter int AW   = vga_pkg::AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [8:0]    row,
    input  logic [9:0]    col,
    input  logic          rdn,
    input  logic          vs,
    output logic [11:0]   Din,
    output logic          mem_req,
    output logic [AW-1:0] mem_addr,
    input  logic          mem_ack,
    input  logic [11:0]   mem_data,
    output logic          underrun
);

    import vga_pkg::*;

    localparam int IW = $clog2(FB_W);

    fetch_state_t  state;
    logic          vs_q;
    logic          rdn_q;
    logic [IW-1:0] idx;
    logic          bank;

    logic          frame_trig;
    logic          line_trig;
    logic          trig;
    logic [7:0]    trig_line;
    logic          trig_bank;
    logic [AW-1:0] trig_base;
    logic          we;
    logic          last;
    logic [11:0]   rdata;

    assign frame_trig = vs & ~vs_q;
    assign line_trig  = rdn_q & ~rdn & ~row[0]
                      & (row[8:1] < 8'(FB_H - 1));
    assign trig       = frame_trig | line_trig;

    assign trig_line  = frame_trig ? 8'd0 : row[8:1] + 8'd1;
    assign trig_bank  = frame_trig ? 1'b0 : ~row[1];

    // line*320 as a shift-add, no multiplier
    assign trig_base  = (AW'(trig_line) << 8) + (AW'(trig_line) << 6);

    assign we   = (state == ST_FETCH) & mem_ack;
    assign last = (idx == IW'(FB_W - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            mem_req  <= 1'b0;
            mem_addr <= '0;
            idx      <= '0;
            bank     <= 1'b0;
            underrun <= 1'b0;
            vs_q     <= 1'b1;
            rdn_q    <= 1'b0;
        end else begin
            vs_q  <= vs;
            rdn_q <= rdn;
            if (trig) begin
                // a pending fetch is abandoned; written words stay
                if (state == ST_FETCH)
                    underrun <= 1'b1;
                state    <= ST_FETCH;
                mem_req  <= 1'b1;
                mem_addr <= trig_base;
                idx      <= '0;
                bank     <= trig_bank;
            end else if (we) begin
                if (last) begin
                    state   <= ST_IDLE;
                    mem_req <= 1'b0;
                    idx     <= '0;
                end else begin
                    idx      <= idx + IW'(1);
                    mem_addr <= mem_addr + AW'(1);
                end
            end
        end
    end

    line_buffer_2bank #(
        .DEPTH (FB_W),
        .W     (PIX_W),
        .IW    (IW)
    ) u_buf (
        .clk   (clk),
        .we    (we),
        .wbank (bank),
        .waddr (idx),
        .wdata (mem_data),
        .rbank (row[1]),
        .raddr (IW'(col[9:1])),
        .rdata (rdata)
    );

    assign Din = (!rdn && (col < 10'(ACT_W))) ? rdata : 12'h000;

endmodule

// File: tb/tb_vga_line_prefetch.sv
// Randomized bench for vga_line_prefetch against a framebuffer model
// where every video-memory word equals its address[11:0].
module tb_vga_line_prefetch;

    import vga_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [8:0]  row;
    logic [9:0]  col;
    logic        rdn;
    logic        vs;
    logic [11:0] Din;
    logic        mem_req;
    logic [16:0] mem_addr;
    logic        mem_ack;
    logic [11:0] mem_data;
    logic        underrun;

    int n_chk  = 0;
    int n_pass = 0;

    int ack_mode  = 0;
    int exp_next  = 0;
    int ack_cnt   = 0;
    int last_addr = 0;
    logic        prev_req  = 1'b0;
    logic        prev_ack  = 1'b0;
    logic [16:0] prev_addr = '0;
    logic        go;

    always #20 clk = ~clk;

    vga_line_prefetch dut (
        .clk      (clk),
        .rst      (rst),
        .row      (row),
        .col      (col),
        .rdn      (rdn),
        .vs       (vs),
        .Din      (Din),
        .mem_req  (mem_req),
        .mem_addr (mem_addr),
        .mem_ack  (mem_ack),
        .mem_data (mem_data),
        .underrun (underrun)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic int word_of(input int line, input int i);
        return (line * FB_W + i) & 12'hfff;
    endfunction

    // memory responder: 0 none, 1 every cycle, 2 random, 3 forced ack
    initial begin
        mem_ack  = 1'b0;
        mem_data = '0;
        forever begin
            @(negedge clk);
            if (ack_mode == 2 && mem_req && prev_req && !prev_ack)
                check("addr_hold", mem_addr, prev_addr);
            if (ack_mode == 1)
                go = mem_req;
            else if (ack_mode == 2)
                go = mem_req && ($urandom_range(0, 2) == 0);
            else if (ack_mode == 3)
                go = 1'b1;
            else
                go = 1'b0;
            mem_ack  = go;
            mem_data = mem_addr[11:0];
            if (go && mem_req) begin
                check("ack_addr", mem_addr, exp_next);
                last_addr = mem_addr;
                exp_next++;
                ack_cnt++;
            end
            prev_req  = mem_req;
            prev_ack  = go && mem_req;
            prev_addr = mem_addr;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic expect_line(input int line);
        exp_next = line * FB_W;
        ack_cnt  = 0;
    endtask

    task automatic fire_line(input int r);
        rdn = 1'b1;
        row = 9'(r);
        @(negedge clk);
        rdn = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_idle(input int limit, output int cyc);
        cyc = 0;
        while (mem_req && cyc < limit) begin
            @(negedge clk);
            cyc++;
        end
        if (mem_req)
            check("idle_timeout", 1, 0);
    endtask

    // odd rows never trigger a fetch; row[1] picks the bank
    task automatic read_at(input string tag, input int bank, input int i,
                           input int exp);
        row = (bank != 0) ? 9'd3 : 9'd1;
        rdn = 1'b0;
        col = 10'(2 * i + int'($urandom_range(0, 1)));
        #1;
        check(tag, Din, exp);
    endtask

    task automatic read_rand(input string tag, input int bank,
                             input int line);
        int i;
        for (int k = 0; k < 4; k++) begin
            i = $urandom_range(0, FB_W - 1);
            read_at(tag, bank, i, word_of(line, i));
        end
    endtask

    initial begin
        int cyc;
        int n;
        rst = 1'b1;
        row = '0;
        col = '0;
        rdn = 1'b1;
        vs  = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("rst_req", mem_req, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_underrun", underrun, 0);
        rst = 1'b0;
        @(negedge clk);

        ack_mode = 1;
        expect_line(0);
        vs = 1'b0;
        repeat (2) @(negedge clk);
        vs = 1'b1;
        @(negedge clk);
        check("frame_req", mem_req, 1);
        check("frame_addr0", mem_addr, 0);
        wait_idle(1000, cyc);
        check("frame_cyc", cyc, FB_W);
        check("frame_acks", ack_cnt, FB_W);
        check("frame_last", last_addr, FB_W - 1);

        row = 9'd0;
        col = 10'd5;
        rdn = 1'b0;
        #1 check("din_col5", Din, 12'h002);
        col = 10'd640;
        #1 check("din_col640", Din, 0);
        col = 10'd5;
        rdn = 1'b1;
        #1 check("din_blank", Din, 0);
        read_rand("bank0_line0", 0, 0);
        @(negedge clk);

        expect_line(4);
        fire_line(6);
        check("l4_req", mem_req, 1);
        check("l4_first", mem_addr, 1280);
        wait_idle(1000, cyc);
        check("l4_acks", ack_cnt, FB_W);
        check("l4_last", last_addr, 1599);
        read_rand("bank0_line4", 0, 4);

        fire_line(7);
        @(negedge clk);
        check("no_trig_r7", mem_req, 0);
        fire_line(478);
        @(negedge clk);
        check("no_trig_r478", mem_req, 0);

        ack_mode = 2;
        expect_line(5);
        fire_line(8);
        check("bp_first", mem_addr, 1600);
        wait_idle(4000, cyc);
        check("bp_budget", cyc < 1600, 1);
        check("bp_acks", ack_cnt, FB_W);
        read_rand("bank1_line5", 1, 5);

        ack_mode = 0;
        expect_line(6);
        fire_line(10);
        check("stall_first", mem_addr, 1920);
        repeat (20) @(negedge clk);
        check("stall_addr", mem_addr, 1920);
        check("stall_req", mem_req, 1);
        check("stall_no_ur", underrun, 0);
        expect_line(7);
        fire_line(12);
        check("ur_set", underrun, 1);
        check("ur_restart", mem_addr, 2240);
        ack_mode = 1;
        wait_idle(1000, cyc);
        check("ur_acks", ack_cnt, FB_W);
        check("ur_sticky", underrun, 1);
        read_rand("bank1_line7", 1, 7);

        expect_line(8);
        fire_line(14);
        repeat (50) @(negedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        ack_mode = 3;
        n = ack_cnt;
        #1;
        check("mid_rst_req", mem_req, 0);
        check("mid_rst_addr", mem_addr, 0);
        check("mid_rst_ur", underrun, 0);
        repeat (3) @(negedge clk);
        ack_mode = 0;
        rst = 1'b0;
        check("mid_rst_partial", (n > 0) && (n < FB_W), 1);
        read_at("rst_w0", 0, 0, word_of(8, 0));
        read_at("rst_wlast", 0, n - 1, word_of(8, n - 1));
        read_at("rst_wnext", 0, n, word_of(4, n));
        read_at("rst_wend", 0, FB_W - 1, word_of(4, FB_W - 1));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
